// File: rtl/mcpu_alu_core.sv
// rtl/mcpu_alu_core.sv - MCPU datapath ALU with registered result and sticky carry flag
//
// Combinational AND/OR/XOR/ADD on two word operands, plus a one-cycle
// registered copy of the result and a carry flag that stays set until reset.
//
// Ports:
//   clk         system clock, rising-edge state updates
//   rst_n       asynchronous active-low reset for the registered outputs
//   opcode      operation select (0 AND, 1 OR, 2 XOR, anything else ADD)
//   r1, r2      operands
//   out         combinational result
//   OVERFLOW    combinational unsigned carry-out of ADD, 0 for logic ops
//   out_q       out captured at the previous rising edge
//   ovf_q       OVERFLOW captured at the previous rising edge
//   ovf_sticky  set by any captured carry-out, cleared only by reset

module mcpu_alu_core #(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CMD_SIZE-1:0]  opcode,
  input  logic [WORD_SIZE-1:0] r1,
  input  logic [WORD_SIZE-1:0] r2,
  output logic [WORD_SIZE-1:0] out,
  output logic                 OVERFLOW,
  output logic [WORD_SIZE-1:0] out_q,
  output logic                 ovf_q,
  output logic                 ovf_sticky
);

  localparam logic [CMD_SIZE-1:0] CMD_AND = CMD_SIZE'(0);
  localparam logic [CMD_SIZE-1:0] CMD_OR  = CMD_SIZE'(1);
  localparam logic [CMD_SIZE-1:0] CMD_XOR = CMD_SIZE'(2);

  // One extra bit so the carry-out falls out of the add directly.
  logic [WORD_SIZE:0] sum;

  assign sum = {1'b0, r1} + {1'b0, r2};

  // Every opcode outside the three logic ops decodes as ADD, so unused
  // encodings at wider CMD_SIZE never produce unknown results.
  always_comb begin
    out      = '0;
    OVERFLOW = 1'b0;
    case (opcode)
      CMD_AND: out = r1 & r2;
      CMD_OR:  out = r1 | r2;
      CMD_XOR: out = r1 ^ r2;
      default: {OVERFLOW, out} = sum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      ovf_q      <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      out_q      <= out;
      ovf_q      <= OVERFLOW;
      ovf_sticky <= ovf_sticky | OVERFLOW;
    end
  end

endmodule

// File: tb/tb_mcpu_alu_core.sv
// tb/tb_mcpu_alu_core.sv - scoreboard bench for mcpu_alu_core

module tb_mcpu_alu_core;

  logic       clk;
  logic       rst_n;

  logic [1:0] opcode;
  logic [1:0] r1;
  logic [1:0] r2;
  logic [1:0] out;
  logic       ovf;
  logic [1:0] out_q;
  logic       ovf_q;
  logic       ovf_sticky;

  logic [2:0] opcode_w;
  logic [7:0] r1_w;
  logic [7:0] r2_w;
  logic [7:0] out_w;
  logic       ovf_w;
  logic [7:0] out_q_w;
  logic       ovf_q_w;
  logic       ovf_sticky_w;

  int total = 0;
  int bad   = 0;

  // kind 0: small comb {OVERFLOW,out}; 1: small registered; 2: wide comb
  typedef struct {
    string      name;
    int         kind;
    logic [7:0] eo;
    logic       eovf;
    logic       esticky;
    time        due;
  } exp_t;

  exp_t sbq[$];

  mcpu_alu_core #(.CMD_SIZE(2), .WORD_SIZE(2)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .r1         (r1),
    .r2         (r2),
    .out        (out),
    .OVERFLOW   (ovf),
    .out_q      (out_q),
    .ovf_q      (ovf_q),
    .ovf_sticky (ovf_sticky)
  );

  mcpu_alu_core #(.CMD_SIZE(3), .WORD_SIZE(8)) u_dut_w (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode_w),
    .r1         (r1_w),
    .r2         (r2_w),
    .out        (out_w),
    .OVERFLOW   (ovf_w),
    .out_q      (out_q_w),
    .ovf_q      (ovf_q_w),
    .ovf_sticky (ovf_sticky_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string n, input int k, input logic [7:0] o,
                      input logic v, input logic s, input int dly);
    exp_t e;
    e.name    = n;
    e.kind    = k;
    e.eo      = o;
    e.eovf    = v;
    e.esticky = s;
    e.due     = $time + dly;
    sbq.push_back(e);
  endtask

  task automatic apply(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] eo, input logic ev, input string n);
    opcode = op;
    r1     = a;
    r2     = b;
    push(n, 0, {6'd0, eo}, ev, 1'b0, 4);
    #20;
  endtask

  task automatic apply_w(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eo, input logic ev, input string n);
    opcode_w = op;
    r1_w     = a;
    r2_w     = b;
    push(n, 2, eo, ev, 1'b0, 4);
    #20;
  endtask

  // Monitor: compares each queued expectation once its sample time arrives.
  initial begin
    exp_t e;
    forever begin
      #1;
      while (sbq.size() > 0 && sbq[0].due <= $time) begin
        e = sbq.pop_front();
        total++;
        case (e.kind)
          0: if ({ovf, out} !== {e.eovf, e.eo[1:0]}) begin
               bad++;
               $display("FAIL %s: got ovf=%b out=%b, want ovf=%b out=%b",
                        e.name, ovf, out, e.eovf, e.eo[1:0]);
             end
          1: if ({out_q, ovf_q, ovf_sticky} !== {e.eo[1:0], e.eovf, e.esticky}) begin
               bad++;
               $display("FAIL %s: got out_q=%b ovf_q=%b sticky=%b, want out_q=%b ovf_q=%b sticky=%b",
                        e.name, out_q, ovf_q, ovf_sticky, e.eo[1:0], e.eovf, e.esticky);
             end
          default: if ({ovf_w, out_w} !== {e.eovf, e.eo}) begin
               bad++;
               $display("FAIL %s: got ovf=%b out=%h, want ovf=%b out=%h",
                        e.name, ovf_w, out_w, e.eovf, e.eo);
             end
        endcase
      end
    end
  end

  initial begin
    logic [1:0] op, a, b, eo;
    logic       ev;
    logic [2:0] s3;

    rst_n    = 1'b0;
    opcode   = 2'd0;
    r1       = 2'd0;
    r2       = 2'd0;
    opcode_w = 3'd0;
    r1_w     = 8'd0;
    r2_w     = 8'd0;

    push("reset_state", 1, 8'd0, 1'b0, 1'b0, 3);
    #10;
    rst_n = 1'b1;

    // Directed combinational vectors (hand-computed)
    apply(2'd0, 2'b11, 2'b10, 2'b10, 1'b0, "and_11_10");
    apply(2'd1, 2'b01, 2'b10, 2'b11, 1'b0, "or_01_10");
    apply(2'd2, 2'b11, 2'b01, 2'b10, 1'b0, "xor_11_01");
    apply(2'd3, 2'b01, 2'b01, 2'b10, 1'b0, "add_01_01");
    apply(2'd3, 2'b11, 2'b11, 2'b10, 1'b1, "add_11_11");
    apply(2'd3, 2'b00, 2'b00, 2'b00, 1'b0, "add_00_00");
    apply(2'd3, 2'b11, 2'b01, 2'b00, 1'b1, "add_11_01");
    apply(2'd2, 2'b11, 2'b11, 2'b00, 1'b0, "xor_11_11");

    // Reset pulse between edges so the sticky flag starts clear
    opcode = 2'd0;
    r1     = 2'b00;
    r2     = 2'b00;
    #2 rst_n = 1'b0;
    push("pulse_clear", 1, 8'd0, 1'b0, 1'b0, 1);
    #2 rst_n = 1'b1;
    #6;

    // Registered path
    opcode = 2'd3;
    r1     = 2'b11;
    r2     = 2'b01;
    push("reg_add_comb", 0, 8'd0, 1'b1, 1'b0, 4);
    push("reg_add_q", 1, 8'd0, 1'b1, 1'b1, 9);
    #10;
    opcode = 2'd0;
    r1     = 2'b11;
    r2     = 2'b10;
    push("reg_and_q", 1, 8'd2, 1'b0, 1'b1, 9);
    #10;

    // Async reset between edges
    #2 rst_n = 1'b0;
    push("async_clear", 1, 8'd0, 1'b0, 1'b0, 1);
    push("async_comb_and", 0, 8'd2, 1'b0, 1'b0, 1);
    #2;
    opcode = 2'd3;
    r1     = 2'b11;
    r2     = 2'b11;
    push("async_comb_add", 0, 8'd2, 1'b1, 1'b0, 4);
    push("async_held", 1, 8'd0, 1'b0, 1'b0, 5);
    #8 rst_n = 1'b1;
    push("release_no_edge", 1, 8'd0, 1'b0, 1'b0, 1);
    push("release_first_edge", 1, 8'd2, 1'b1, 1'b1, 7);
    #8;

    // Random regression against a bench model
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 2'($urandom_range(0, 3));
      b  = 2'($urandom_range(0, 3));
      ev = 1'b0;
      case (op)
        2'd0:    eo = a & b;
        2'd1:    eo = a | b;
        2'd2:    eo = a ^ b;
        default: begin
          s3 = {1'b0, a} + {1'b0, b};
          eo = s3[1:0];
          ev = s3[2];
        end
      endcase
      apply(op, a, b, eo, ev, $sformatf("rand_%0d", i));
    end

    // Wide instance: CMD_SIZE=3, WORD_SIZE=8
    apply_w(3'b101, 8'hFF, 8'h01, 8'h00, 1'b1, "w_op5_ff_01");
    apply_w(3'b101, 8'h12, 8'h34, 8'h46, 1'b0, "w_op5_12_34");
    apply_w(3'b111, 8'h80, 8'h80, 8'h00, 1'b1, "w_op7_80_80");
    apply_w(3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0, "w_op3_f0_0f");
    apply_w(3'b010, 8'hA5, 8'hFF, 8'h5A, 1'b0, "w_xor");
    apply_w(3'b000, 8'hA5, 8'h3C, 8'h24, 1'b0, "w_and");
    apply_w(3'b001, 8'hA0, 8'h05, 8'hA5, 1'b0, "w_or");

    for (int i = 0; i < 100 && sbq.size() > 0; i++) #1;
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
